// File: rtl/kernel_window_sequencer_if.sv
// Pixel-stream side of the kernel window sequencer.
// The master modport drives the receiver's accept strobes.
// The slave modport is the sequencer, which returns the window and frame status.
interface kernel_window_sequencer_if #(
  parameter int unsigned IMAGE_WIDTH  = 4096,
  parameter int unsigned IMAGE_HEIGHT = 4096
);
  localparam int unsigned COL_W = $clog2(IMAGE_WIDTH);
  localparam int unsigned ROW_W = $clog2(IMAGE_HEIGHT);

  logic             i_data_valid;
  logic             i_start_of_frame;
  logic             i_end_of_line;
  logic             o_window_valid;
  logic [COL_W-1:0] o_center_col;
  logic [ROW_W-1:0] o_center_row;
  logic             o_frame_done;
  logic             o_busy;
  logic             o_sof_err;
  logic             o_line_err;

  modport master (
    output i_data_valid, i_start_of_frame, i_end_of_line,
    input  o_window_valid, o_center_col, o_center_row, o_frame_done, o_busy, o_sof_err,
           o_line_err
  );

  modport slave (
    input  i_data_valid, i_start_of_frame, i_end_of_line,
    output o_window_valid, o_center_col, o_center_row, o_frame_done, o_busy, o_sof_err,
           o_line_err
  );
endinterface

// File: rtl/kernel_window_sequencer.sv
// Tracks the (row, col) of each pixel accepted by the 5x5 window receiver.
// Flags buffer states that hold a complete in-frame window, one cycle after the accept.
// Optional line-length checking on tlast is enabled by defining WIN_EOL_CHECK_EN.
module kernel_window_sequencer #(
  parameter int unsigned KERNEL_SIZE  = 5,
  parameter int unsigned IMAGE_WIDTH  = 4096,
  parameter int unsigned IMAGE_HEIGHT = 4096,
  parameter int unsigned COL_W        = $clog2(IMAGE_WIDTH),
  parameter int unsigned ROW_W        = $clog2(IMAGE_HEIGHT)
) (
  input  logic                        i_clk,
  input  logic                        i_aresetn,
  kernel_window_sequencer_if.slave    io_win
);

  localparam logic [COL_W-1:0] LAST_COL = COL_W'(IMAGE_WIDTH - 1);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(IMAGE_HEIGHT - 1);
  localparam logic [COL_W-1:0] MIN_COL  = COL_W'(KERNEL_SIZE - 1);
  localparam logic [ROW_W-1:0] MIN_ROW  = ROW_W'(KERNEL_SIZE - 1);
  localparam logic [COL_W-1:0] RAD_COL  = COL_W'(KERNEL_SIZE / 2);
  localparam logic [ROW_W-1:0] RAD_ROW  = ROW_W'(KERNEL_SIZE / 2);

  typedef enum logic [0:0] {StIdle, StActive} state_e;

  state_e           r_state;
  logic [COL_W-1:0] r_col;
  logic [ROW_W-1:0] r_row;
  logic             r_resync;
  logic             r_window_valid;
  logic [COL_W-1:0] r_center_col;
  logic [ROW_W-1:0] r_center_row;
  logic             r_frame_done;
  logic             r_sof_err;
  logic             r_line_err;

  state_e           w_state_nxt;
  logic [COL_W-1:0] w_col_nxt;
  logic [ROW_W-1:0] w_row_nxt;
  logic [ROW_W-1:0] w_row_inc;
  logic             w_resync_nxt;
  logic             w_accept;
  logic             w_window;
  logic [COL_W-1:0] w_center_col_nxt;
  logic [ROW_W-1:0] w_center_row_nxt;
  logic             w_frame_done_nxt;
  logic             w_sof_err_nxt;
  logic             w_line_err_nxt;
  logic             w_at_last_col;

  // Row increment that never leaves the frame, even on a resync in the last line.
  assign w_row_inc = (r_row == LAST_ROW) ? '0 : r_row + ROW_W'(1);

  // Next-state, position and status decode for the accepted pixel.
  always_comb begin
    w_state_nxt      = r_state;
    w_col_nxt        = r_col;
    w_row_nxt        = r_row;
    w_resync_nxt     = r_resync;
    w_accept         = 1'b0;
    w_frame_done_nxt = 1'b0;
    w_sof_err_nxt    = 1'b0;
    w_line_err_nxt   = r_line_err;
    w_at_last_col    = 1'b0;

    unique case (r_state)
      StIdle: begin
        // Pixels before a start of frame are not counted.
        if (io_win.i_data_valid && io_win.i_start_of_frame) begin
          w_accept     = 1'b1;
          w_state_nxt  = StActive;
          w_col_nxt    = '0;
          w_row_nxt    = '0;
          w_resync_nxt = 1'b0;
        end
      end
      StActive: begin
        if (io_win.i_data_valid) begin
          w_accept     = 1'b1;
          w_resync_nxt = 1'b0;
          if (io_win.i_start_of_frame) begin
            // Abandon the partial frame; sof wins even over the last pixel.
            w_sof_err_nxt = 1'b1;
            w_col_nxt     = '0;
            w_row_nxt     = '0;
          end else begin
            if ((r_col == LAST_COL) || r_resync) begin
              w_col_nxt = '0;
              w_row_nxt = w_row_inc;
            end else begin
              w_col_nxt = r_col + COL_W'(1);
            end
            if ((w_col_nxt == LAST_COL) && (w_row_nxt == LAST_ROW)) begin
              w_frame_done_nxt = 1'b1;
              w_state_nxt      = StIdle;
            end
          end
`ifdef WIN_EOL_CHECK_EN
          w_at_last_col = (w_col_nxt == LAST_COL);
          if (io_win.i_end_of_line != w_at_last_col) begin
            w_line_err_nxt = 1'b1;
          end
          // Early tlast forces the next pixel onto the start of the following line.
          if (io_win.i_end_of_line && !w_at_last_col) begin
            w_resync_nxt = 1'b1;
          end
`endif
        end
      end
      default: w_state_nxt = StIdle;
    endcase
  end

`ifndef WIN_EOL_CHECK_EN
  logic w_unused_eol;
  assign w_unused_eol = io_win.i_end_of_line ^ w_at_last_col;
`endif

  // Window qualification on the position of the pixel just accepted.
  always_comb begin
    w_window         = w_accept && (w_row_nxt >= MIN_ROW) && (w_col_nxt >= MIN_COL);
    w_center_col_nxt = r_center_col;
    w_center_row_nxt = r_center_row;
    if (w_window) begin
      w_center_col_nxt = w_col_nxt - RAD_COL;
      w_center_row_nxt = w_row_nxt - RAD_ROW;
    end
  end

  // State, counters and registered outputs aligned with the receiver's buffer update.
  always_ff @(posedge i_clk or negedge i_aresetn) begin
    if (!i_aresetn) begin
      r_state        <= StIdle;
      r_col          <= '0;
      r_row          <= '0;
      r_resync       <= 1'b0;
      r_window_valid <= 1'b0;
      r_center_col   <= '0;
      r_center_row   <= '0;
      r_frame_done   <= 1'b0;
      r_sof_err      <= 1'b0;
      r_line_err     <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_col          <= w_col_nxt;
      r_row          <= w_row_nxt;
      r_resync       <= w_resync_nxt;
      r_window_valid <= w_window;
      r_center_col   <= w_center_col_nxt;
      r_center_row   <= w_center_row_nxt;
      r_frame_done   <= w_frame_done_nxt;
      r_sof_err      <= w_sof_err_nxt;
      r_line_err     <= w_line_err_nxt;
    end
  end

  assign io_win.o_window_valid = r_window_valid;
  assign io_win.o_center_col   = r_center_col;
  assign io_win.o_center_row   = r_center_row;
  assign io_win.o_frame_done   = r_frame_done;
  assign io_win.o_busy         = (r_state == StActive);
  assign io_win.o_sof_err      = r_sof_err;
  assign io_win.o_line_err     = r_line_err;

endmodule

// File: tb/tb_kernel_window_sequencer.sv
// Directed bench for kernel_window_sequencer with K=5, W=16, H=8.
// Expected positions come from the stream index: r = idx/16, c = idx%16.
module tb_kernel_window_sequencer;

  logic clk = 1'b0;
  logic rstn = 1'b0;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  int unsigned exp_cr = 0;
  int unsigned exp_cc = 0;
  int unsigned exp_lerr = 0;

  always #5 clk = ~clk;

  kernel_window_sequencer_if #(.IMAGE_WIDTH(16), .IMAGE_HEIGHT(8)) bus ();

  kernel_window_sequencer #(
    .KERNEL_SIZE (5),
    .IMAGE_WIDTH (16),
    .IMAGE_HEIGHT(8)
  ) dut (
    .i_clk    (clk),
    .i_aresetn(rstn),
    .io_win   (bus)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic drive(input bit v, input bit s, input bit e);
    bus.i_data_valid     = v;
    bus.i_start_of_frame = s;
    bus.i_end_of_line    = e;
    @(posedge clk);
    #1;
  endtask

  task automatic check_held();
    check_eq("center_row", 32'(bus.o_center_row), exp_cr);
    check_eq("center_col", 32'(bus.o_center_col), exp_cc);
    check_eq("line_err", 32'(bus.o_line_err), exp_lerr);
  endtask

  task automatic check_quiet(input string tag, input int unsigned busy);
    check_eq({tag, "_win"}, 32'(bus.o_window_valid), 0);
    check_eq({tag, "_done"}, 32'(bus.o_frame_done), 0);
    check_eq({tag, "_sof_err"}, 32'(bus.o_sof_err), 0);
    check_eq({tag, "_busy"}, 32'(bus.o_busy), busy);
    check_held();
  endtask

  task automatic apply_reset();
    bus.i_data_valid     = 1'b0;
    bus.i_start_of_frame = 1'b0;
    bus.i_end_of_line    = 1'b0;
    rstn = 1'b0;
    #2;
    exp_cr   = 0;
    exp_cc   = 0;
    exp_lerr = 0;
    check_quiet("reset", 0);
    @(posedge clk);
    #1;
    check_quiet("reset_hold", 0);
    rstn = 1'b1;
  endtask

  // Streams one frame; restart_at re-asserts sof at that stream index, eol_at pulses an
  // early tlast at that stream index.
  task automatic run_frame(input string name, input bit gaps, input int restart_at,
                           input int eol_at);
    int k = 0, base = 0, shift = 0, idx = 0, r = 0, c = 0;
    int n_win = 0, n_done = 0, n_serr = 0, first_win = -1, budget = 0;
    bit done = 0, sof, eol, exp_win;
    while (!done && budget < 2000) begin
      budget++;
      if (gaps && ($urandom_range(1) == 0)) begin
        drive(0, 0, 0);
        check_quiet({name, "_gap"}, (k != 0) ? 1 : 0);
      end else begin
        sof = (k == 0) || (k == restart_at);
        if (k == restart_at) begin
          base      = k;
          shift     = 0;
          n_win     = 0;
          first_win = -1;
        end
        idx = k - base + shift;
        r   = idx / 16;
        c   = idx % 16;
        eol = (c == 15) || (k == eol_at);
        drive(1, sof, eol);
        exp_win = (r >= 4) && (c >= 4);
        if (exp_win) begin
          exp_cr = r - 2;
          exp_cc = c - 2;
        end
`ifdef WIN_EOL_CHECK_EN
        if ((k == eol_at) && (c != 15)) begin
          exp_lerr = 1;
          shift += 15 - c;
        end
`endif
        check_eq({name, "_win"}, 32'(bus.o_window_valid), exp_win ? 1 : 0);
        check_eq({name, "_done"}, 32'(bus.o_frame_done), (idx == 127) ? 1 : 0);
        check_eq({name, "_sof_err"}, 32'(bus.o_sof_err), (sof && k != 0) ? 1 : 0);
        check_eq({name, "_busy"}, 32'(bus.o_busy), (idx != 127) ? 1 : 0);
        check_held();
        if (bus.o_window_valid) begin
          n_win++;
          if (first_win < 0) first_win = idx;
        end
        n_done += int'(bus.o_frame_done);
        n_serr += int'(bus.o_sof_err);
        if (idx == 127) done = 1;
        k++;
      end
    end
    check_eq({name, "_complete"}, 32'(done), 1);
    check_eq({name, "_n_windows"}, n_win, 48);
    check_eq({name, "_first_window"}, first_win, 68);
    check_eq({name, "_n_frame_done"}, n_done, 1);
    check_eq({name, "_n_sof_err"}, n_serr, (restart_at > 0) ? 1 : 0);
    drive(0, 0, 0);
    check_quiet({name, "_after"}, 0);
  endtask

  initial begin
    bus.i_data_valid     = 1'b0;
    bus.i_start_of_frame = 1'b0;
    bus.i_end_of_line    = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    check_quiet("por", 0);
    rstn = 1'b1;
    drive(0, 0, 0);
    check_quiet("idle", 0);

    run_frame("cont", 0, -1, -1);
    run_frame("gaps", 1, -1, -1);

    // Pixels without sof are ignored while idle.
    for (int i = 0; i < 10; i++) begin
      drive(1, 0, (i % 16) == 15);
      check_quiet("pre_sof", 0);
    end
    run_frame("after_junk", 0, -1, -1);

    run_frame("restart40", 0, 40, -1);
    run_frame("sof_on_last", 0, 127, -1);

    // Reset part way through a frame, then confirm idle behaviour until sof.
    for (int i = 0; i < 50; i++) begin
      drive(1, i == 0, (i % 16) == 15);
    end
    check_eq("mid_busy", 32'(bus.o_busy), 1);
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      drive(1, 0, 0);
      check_quiet("post_reset", 0);
    end
    run_frame("post_reset_frame", 0, -1, -1);

    // Early tlast at r2 c10.
    run_frame("eol", 0, -1, 42);
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0);
      check_quiet("eol_sticky", 0);
    end
    apply_reset();
    drive(0, 0, 0);
    check_quiet("final", 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
